// File: rtl/ram_sdp_clr.sv
// Simple-dual-port synchronous RAM with per-byte write enables, registered read
// with valid strobe, selectable collision behaviour and a built-in clear sequencer.
//
//   state | meaning
//   ------+-------------------------------------------------------------
//   CLEAR | writing CLR_VAL to mem[ptr] each cycle; ports ignored, busy=1
//   READY | normal read/write service; clr restarts the clear sequence
module ram_sdp_clr #(
   parameter int                DATA_W  = 16,
   parameter int                ADDR_W  = 3,
   parameter int                DEPTH   = 8,
   parameter int                RD_MODE = 0,
   parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  clr,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_W-1:0]     wdata,
   input  logic [DATA_W/8-1:0]   wbe,
   input  logic                  re,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_W-1:0]     rdata,
   output logic                  rvalid,
   output logic                  busy
);

   localparam int                NB      = DATA_W / 8;
   localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

   typedef enum logic {CLEAR, READY} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   ptr;
   logic [DATA_W-1:0]   mem [DEPTH];

   logic                waddr_ok;
   logic                raddr_ok;
   logic                wr_en;
   logic [DATA_W-1:0]   rd_old;
   logic [DATA_W-1:0]   rd_word;

   assign waddr_ok = ({1'b0, waddr} < DEPTH_L);
   assign raddr_ok = ({1'b0, raddr} < DEPTH_L);
   assign wr_en    = (state == READY) && we && !clr && waddr_ok;

   // Write-first forwards the merged word so disabled lanes still show old data.
   always_comb begin
      rd_old  = raddr_ok ? mem[raddr] : '0;
      rd_word = rd_old;
      if (RD_MODE == 1 && we && raddr_ok && (waddr == raddr)) begin
         for (int i = 0; i < NB; i++) begin
            if (wbe[i]) rd_word[8*i +: 8] = wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[ptr] <= CLR_VAL;
      end else if (wr_en) begin
         for (int i = 0; i < NB; i++) begin
            if (wbe[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= CLEAR;
         ptr    <= '0;
         busy   <= 1'b1;
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         case (state)
            CLEAR: begin
               rvalid <= 1'b0;
               if (ptr == LAST) begin
                  state <= READY;
                  busy  <= 1'b0;
                  ptr   <= '0;
               end else begin
                  ptr <= ptr + ADDR_W'(1);
               end
            end
            READY: begin
               if (clr) begin
                  state  <= CLEAR;
                  busy   <= 1'b1;
                  ptr    <= '0;
                  rvalid <= 1'b0;
               end else begin
                  rvalid <= re;
                  if (re) rdata <= rd_word;
               end
            end
            default: begin
               state <= CLEAR;
               busy  <= 1'b1;
               ptr   <= '0;
            end
         endcase
      end
   end

endmodule

// File: doc/ram_sdp_clr.md
Name: ram_sdp_clr

Overview:
Parametrised simple-dual-port synchronous RAM. It is the successor to the fixed 8x8 single-port RAM. It adds width and depth parameters, per-byte write enables, a registered read with a valid strobe, and a configurable read/write collision mode. A built-in clear sequencer zeroes the array after reset or on request. It serves as the general scratch and buffer memory for datapath blocks.

Parameters:
DATA_W, 16, data width in bits; must be a multiple of 8.
ADDR_W, 3, address width in bits.
DEPTH, 8, number of words; DEPTH <= 2**ADDR_W.
RD_MODE, 0, collision mode: 0 = read-first (old data), 1 = write-first (new data).
CLR_VAL, 0, value written to every word by the clear sequencer.

Ports:
clk  in  1  system clock; everything is on its rising edge.
rst_n  in  1  asynchronous active-low reset.
clr  in  1  one-cycle request to clear the array; sampled only in READY.
we  in  1  write enable.
waddr  in  ADDR_W  write address.
wdata  in  DATA_W  write data.
wbe  in  DATA_W/8  byte enables; bit i enables wdata[8i+7:8i].
re  in  1  read enable.
raddr  in  ADDR_W  read address.
rdata  out  DATA_W  registered read data.
rvalid  out  1  high for exactly one cycle when rdata carries a new result.
busy  out  1  high while clearing; we, re and clr are ignored while busy=1.

Behaviour:
- Reset values (rst_n low): rdata=0, rvalid=0, busy=1, state=CLEAR, clear pointer=0. Outputs change immediately on rst_n falling, not at the next edge. Array contents are not reset directly.
- States: CLEAR and READY.
- CLEAR state:
  - Each cycle writes CLR_VAL to mem[ptr], then ptr increments.
  - After the write to DEPTH-1, the next state is READY and busy drops at that same edge.
  - Clearing takes exactly DEPTH cycles after the first rising edge with rst_n high.
  - rvalid stays 0 throughout.
- READY state, clr=1: transition to CLEAR with ptr=0, and busy=1 on the next edge. If we or re is high in the same cycle as clr, both are ignored.
- Write: when we=1 and busy=0, each byte lane with wbe[i]=1 is updated at the edge. Lanes with wbe[i]=0 keep their contents. we=1 with wbe=0 has no effect.
- Read:
  - When re=1 and busy=0, rdata is loaded with mem[raddr] at the edge and rvalid=1 for that cycle. Read latency is 1 cycle.
  - When re=0, rvalid=0 and rdata holds its last value.
  - Back-to-back reads are allowed every cycle.
- Collision (we=1 and re=1, waddr==raddr, same cycle):
  - RD_MODE=0: rdata returns the pre-write word.
  - RD_MODE=1: rdata returns the post-write word, i.e. enabled lanes from wdata and disabled lanes from the old word.
  - The memory is updated in both modes.
- Out-of-range addresses (>= DEPTH): the write is dropped. The read returns 0 with rvalid=1.
- Reset mid-operation: any rst_n low aborts a clear or read in progress. After release, the full clear restarts from address 0.
- The array has no initial-value dependency; all contents are defined only after the first clear completes.

Test Plan:
1. Release rst_n, then count busy -> busy=1 for exactly 8 cycles. Afterwards, reads of addresses 0..7 return 0x0000, each with rvalid one cycle after re.
2. Write addr0=0xAABB (wbe=11) and addr1=0xCCDD, then read addr0 and addr1 back-to-back -> rdata 0xAABB then 0xCCDD on consecutive cycles, rvalid high for 2 cycles.
3. With addr0=0xAABB, write 0x1234 with wbe=01, then read addr0 -> 0xAA34. Write with wbe=00, then read -> still 0xAA34.
4. Set addr2=0x5555, then in one cycle write 0x6666 to addr2 and read addr2 (RD_MODE=0) -> rdata=0x5555; a following read -> 0x6666. Repeat on an RD_MODE=1 instance -> first read returns 0x6666.
5. With data loaded, pulse clr and attempt to write addr3=0xFFFF while busy -> busy high for 8 cycles and the write is ignored. Afterwards all reads return 0x0000, including addr3.
6. Drop rst_n between edges during the 4th clear cycle -> busy=1 and rvalid=0 immediately. After release, busy stays high for a full 8 cycles.
